// File: rtl/cpu_ctl_latch.sv
// cpu_ctl_latch
// Per-CPU control latches for the Namco 6809 multi-CPU boards. One shared
// block serves NCPU CPUs. The main-CPU bus logic decodes control-write
// strobes, and this block turns them into the following per-CPU state:
//   - IRQ enable, with VBLANK interrupts in level or edge-latched mode
//   - interrupt acknowledge
//   - a sub-CPU reset latch with a minimum-width reset stretcher
// Optional feature: define CPU_CTL_WATCHDOG_EN to build in a watchdog that
// counts VBLANK edges. When the macro is undefined, WDT_RST is tied to 0 and
// function code 4 has no effect.

module cpu_ctl_latch #(
    parameter int              NCPU      = 3,
    parameter int              RST_MIN   = 16,
    parameter logic [NCPU-1:0] RST_INIT  = {NCPU{1'b1}},
    parameter int              WDT_LIMIT = 8
) (
    input  logic            CPU_CLK,
    input  logic            RESET,
    input  logic            VBLK,
    input  logic            CTL_CS,
    input  logic [2:0]      CTL_SEL,
    input  logic [2:0]      CTL_FN,
    input  logic            CTL_VAL,
    output logic [NCPU-1:0] IRQ,
    output logic [NCPU-1:0] CPU_RESET,
    output logic            WDT_RST
);

    // Stretch counter width. The counter must hold RST_MIN and is never
    // narrower than 1 bit.
    localparam int RCW = (RST_MIN < 1) ? 1 : $clog2(RST_MIN + 1);
    localparam logic [RCW-1:0] RCNT_LOAD = RCW'(RST_MIN);
    localparam logic [RCW-1:0] RCNT_ONE  = RCW'(1);
    localparam logic [RCW-1:0] RCNT_ZERO = {RCW{1'b0}};

    localparam logic [2:0] FN_IRQ_EN  = 3'd0;
    localparam logic [2:0] FN_RST_LAT = 3'd1;
    localparam logic [2:0] FN_IRQ_ACK = 3'd2;
    localparam logic [2:0] FN_IRQ_MOD = 3'd3;

    // Start value of the stretch counter for a CPU that comes out of reset
    // held in reset.
    function automatic logic [RCW-1:0] rcnt_init(input int idx);
        logic [RCW-1:0] v;
        if (RST_INIT[idx]) begin
            v = RCNT_LOAD;
        end else begin
            v = RCNT_ZERO;
        end
        return v;
    endfunction

    // Registered state
    logic                      vblk_d_r;
    logic [NCPU-1:0]           en_r;
    logic [NCPU-1:0]           mode_r;
    logic [NCPU-1:0]           pend_r;
    logic [NCPU-1:0]           rlat_r;
    logic [NCPU-1:0][RCW-1:0]  rcnt_r;
    logic [NCPU-1:0]           cpu_reset_r;

    // Next-state and decode signals
    logic                      vedge_s;
    logic [NCPU-1:0]           hit_s;
    logic [NCPU-1:0]           clr_s;
    logic [NCPU-1:0]           ack_s;
    logic [NCPU-1:0]           set_s;
    logic [NCPU-1:0]           load_s;
    logic [NCPU-1:0]           en_s;
    logic [NCPU-1:0]           mode_s;
    logic [NCPU-1:0]           pend_s;
    logic [NCPU-1:0]           rlat_s;
    logic [NCPU-1:0][RCW-1:0]  rcnt_s;
    logic [NCPU-1:0]           cpu_reset_s;

    // VBLANK rising edge, plus a one-hot write select. A select index of
    // NCPU or above matches no CPU, so writes to it are dropped.
    always_comb begin
        vedge_s = VBLK & ~vblk_d_r;
        hit_s   = {NCPU{1'b0}};
        for (int i = 0; i < NCPU; i++) begin
            if (CTL_CS && (CTL_SEL == 3'(i))) begin
                hit_s[i] = 1'b1;
            end else begin
                hit_s[i] = 1'b0;
            end
        end
    end

    // Per-CPU function decode and next-state computation.
    always_comb begin
        en_s        = en_r;
        mode_s      = mode_r;
        rlat_s      = rlat_r;
        pend_s      = pend_r;
        rcnt_s      = rcnt_r;
        clr_s       = {NCPU{1'b0}};
        ack_s       = {NCPU{1'b0}};
        load_s      = {NCPU{1'b0}};
        set_s       = {NCPU{1'b0}};
        cpu_reset_s = {NCPU{1'b0}};
        for (int i = 0; i < NCPU; i++) begin
            if (hit_s[i]) begin
                case (CTL_FN)
                    FN_IRQ_EN: begin
                        en_s[i]  = CTL_VAL;
                        clr_s[i] = ~CTL_VAL;
                    end
                    FN_RST_LAT: begin
                        rlat_s[i] = CTL_VAL;
                        load_s[i] = CTL_VAL;
                    end
                    FN_IRQ_ACK: begin
                        ack_s[i] = 1'b1;
                    end
                    FN_IRQ_MOD: begin
                        mode_s[i] = CTL_VAL;
                        clr_s[i]  = 1'b1;
                    end
                    default: begin
                        clr_s[i] = 1'b0;
                    end
                endcase
            end else begin
                clr_s[i] = 1'b0;
            end

            // Set and clear use the enable and mode from before this write.
            // Disable and mode changes beat a set, and a set beats an ack.
            set_s[i] = vedge_s & en_r[i] & mode_r[i];
            if (clr_s[i]) begin
                pend_s[i] = 1'b0;
            end else if (set_s[i]) begin
                pend_s[i] = 1'b1;
            end else if (ack_s[i]) begin
                pend_s[i] = 1'b0;
            end else begin
                pend_s[i] = pend_r[i];
            end

            // Every write of 1 restarts the stretch, even if the latch is
            // already set.
            if (load_s[i]) begin
                rcnt_s[i] = RCNT_LOAD;
            end else if (rcnt_r[i] != RCNT_ZERO) begin
                rcnt_s[i] = rcnt_r[i] - RCNT_ONE;
            end else begin
                rcnt_s[i] = rcnt_r[i];
            end

            // Built from next-state values, so a write reaches CPU_RESET one
            // clock after the strobe.
            cpu_reset_s[i] = rlat_s[i] | (rcnt_s[i] != RCNT_ZERO);
        end
    end

    // Per-CPU latches, with a synchronous return to the reset values.
    always_ff @(posedge CPU_CLK) begin
        if (RESET) begin
            vblk_d_r    <= 1'b0;
            en_r        <= {NCPU{1'b0}};
            mode_r      <= {NCPU{1'b0}};
            pend_r      <= {NCPU{1'b0}};
            rlat_r      <= RST_INIT;
            cpu_reset_r <= RST_INIT;
            for (int i = 0; i < NCPU; i++) begin
                rcnt_r[i] <= rcnt_init(i);
            end
        end else begin
            vblk_d_r    <= VBLK;
            en_r        <= en_s;
            mode_r      <= mode_s;
            pend_r      <= pend_s;
            rlat_r      <= rlat_s;
            rcnt_r      <= rcnt_s;
            cpu_reset_r <= cpu_reset_s;
        end
    end

    // Level mode passes VBLK straight through, gated by the enable. Edge mode
    // presents the latched pending bit.
    assign IRQ       = (mode_r & pend_r) | (~mode_r & en_r & {NCPU{VBLK}});
    assign CPU_RESET = cpu_reset_r;

`ifdef CPU_CTL_WATCHDOG_EN
    localparam logic [8:0] WDT_LIM = 9'(WDT_LIMIT);

    logic       kick_s;
    logic       wdt_fire_s;
    logic [7:0] wdt_cnt_s;
    logic [7:0] wdt_cnt_r;
    logic       wdt_rst_r;

    // Watchdog counter. A kick in the same cycle as a VBLANK edge wins.
    // Reaching the limit fires the watchdog and wraps the count to 0.
    always_comb begin
        kick_s     = CTL_CS & (CTL_FN == 3'd4);
        wdt_fire_s = 1'b0;
        wdt_cnt_s  = wdt_cnt_r;
        if (kick_s) begin
            wdt_cnt_s = 8'd0;
        end else if (vedge_s) begin
            if (({1'b0, wdt_cnt_r} + 9'd1) == WDT_LIM) begin
                wdt_fire_s = 1'b1;
                wdt_cnt_s  = 8'd0;
            end else begin
                wdt_cnt_s = wdt_cnt_r + 8'd1;
            end
        end else begin
            wdt_cnt_s = wdt_cnt_r;
        end
    end

    // Watchdog count and its one-clock request pulse.
    always_ff @(posedge CPU_CLK) begin
        if (RESET) begin
            wdt_cnt_r <= 8'd0;
            wdt_rst_r <= 1'b0;
        end else begin
            wdt_cnt_r <= wdt_cnt_s;
            wdt_rst_r <= wdt_fire_s;
        end
    end

    assign WDT_RST = wdt_rst_r;
`else
    assign WDT_RST = 1'b0;
`endif

endmodule

// File: doc/cpu_ctl_latch.md
# cpu_ctl_latch

Parametrised per-CPU control-latch block for the Namco 6809 multi-CPU boards. It generalises the per-module IRQ-enable and sub-CPU-reset latches into one shared block serving `NCPU` CPUs, driven by decoded control-write strobes from the main CPU bus logic. It adds:
- edge-latched VBLANK interrupts with explicit acknowledge;
- a minimum-width reset stretcher;
- an optional VBLANK-counted watchdog.

## Interface
Parameters:
- `NCPU`, 3, number of controlled CPUs (1..8); index 0 is the main CPU.
- `RST_MIN`, 16, minimum `CPU_RESET` high time in clocks after any reset-assert write (0 = no stretch).
- `RST_INIT`, `{NCPU{1'b1}}`, reset value of the reset latches, one bit per CPU.
- `WDT_LIMIT`, 8, VBLANK rising edges without a kick before the watchdog fires (1..255).

Ports:
- `CPU_CLK` in 1: single clock. Reset is synchronous and active-high.
- `RESET` in 1: synchronous, active-high.
- `VBLK` in 1: vertical blank level, synchronous to `CPU_CLK`.
- `CTL_CS` in 1: one-cycle control-write strobe.
- `CTL_SEL` in 3: target CPU index; values ≥ `NCPU` are ignored.
- `CTL_FN` in 3: function code; 0 IRQ enable, 1 reset latch, 2 IRQ ack, 3 IRQ mode, 4 watchdog kick, 5–7 reserved (no effect).
- `CTL_VAL` in 1: data bit for the function.
- `IRQ` out `NCPU`: interrupt request per CPU, active-high, to the cpu6809 wrapper `irq`.
- `CPU_RESET` out `NCPU`: per-CPU reset, active-high.
- `WDT_RST` out 1: one-cycle watchdog reset request to system reset logic.

## Operation
Per-CPU state:
- `en` (IRQ enable), reset value 0.
- `mode` (0 = level, 1 = edge), reset value 0.
- `pend`, reset value 0.
- `rlat` (reset latch), reset value `RST_INIT[i]`.
- `rcnt`, reset value `RST_MIN` if `RST_INIT[i]`, else 0.

Global state:
- `vblk_d`, reset value 0.
- `wdt_cnt`, reset value 0.

VBLANK edge: `vedge` = `VBLK & ~vblk_d`, where `vblk_d` is registered every clock.

Writes (when `CTL_CS` and `CTL_SEL` < `NCPU`):
- FN0: `en` ← `CTL_VAL`. Writing 0 also clears `pend`.
- FN1: `rlat` ← `CTL_VAL`. Writing 1 also loads `rcnt` ← `RST_MIN`, including when `rlat` is already 1.
- FN2: clears `pend`; `CTL_VAL` is ignored.
- FN3: `mode` ← `CTL_VAL`; always clears `pend`.
- FN4: clears `wdt_cnt`; `CTL_SEL` and `CTL_VAL` are ignored. Only meaningful with the watchdog compiled in.

Pending and IRQ:
- `pend` is set when `vedge & en & mode`.
- Set has priority over an ack (FN2) in the same cycle.
- FN0 write-0 and FN3 clear take priority over set.
- `IRQ[i]` = `en & VBLK` when `mode` = 0 (legacy behaviour); `IRQ[i]` = `pend` when `mode` = 1. `IRQ` is combinational from registers and `VBLK`.

Reset stretch:
- `rcnt` decrements by 1 per clock while nonzero and saturates at 0.
- `CPU_RESET[i]` = `rlat | (rcnt != 0)`, registered.

Width: `rcnt` is `$clog2(RST_MIN+1)` bits, minimum 1.

## Timing
- Latency from a control write to `CPU_RESET` or `IRQ` (edge mode): 1 clock; the new value is visible in the cycle after the `CTL_CS` edge.
- `IRQ` in level mode follows `VBLK` with 0-clock latency once `en` is registered.
- Edge mode: `pend`, and hence `IRQ`, rises 1 clock after the first cycle `VBLK` is high (the `vedge` cycle). A `VBLK` already high at reset produces no edge: `vblk_d` resets to 0, but the edge is masked because `en` = 0.
- Reset stretch: a write of 1 followed immediately by a write of 0 keeps `CPU_RESET` high for exactly `RST_MIN` clocks after the first write (`RST_MIN` = 0: 1 clock).
- `RESET` mid-operation: all state returns to its reset values on the next edge. `WDT_RST` is 0 during and after `RESET`.
- Multiple writes: one function per cycle; there are no back-to-back hazards.

## Configuration
- `CPU_CTL_WATCHDOG_EN` defined:
  - `wdt_cnt` (8-bit) increments on each `vedge`.
  - FN4 clears it; a kick in the same cycle as `vedge` wins (counter becomes 0).
  - When the increment would reach `WDT_LIMIT`, `WDT_RST` pulses high for 1 clock and `wdt_cnt` returns to 0.
- Not defined: `wdt_cnt` is absent, `WDT_RST` is tied to 0, and FN4 is a no-op.

## Test plan
- Reset, `RST_INIT` = 3'b110 → `CPU_RESET` = 3'b110, `IRQ` = 0, `WDT_RST` = 0.
- FN0 sel0 val1, level mode, `VBLK` pulses 5 clocks → `IRQ[0]` high for exactly the 5 `VBLK` clocks; `IRQ[1]` and `IRQ[2]` stay 0.
- FN3 sel1 val1, FN0 sel1 val1, `VBLK` rises and stays high 20 clocks → `IRQ[1]` rises 1 clock after the edge and stays high after `VBLK` falls. FN2 sel1 → `IRQ[1]` low next clock. FN2 issued in the `vedge` cycle → `IRQ[1]` stays high.
- `RST_MIN` = 16: FN1 sel2 val1 then FN1 sel2 val0 on the next cycle → `CPU_RESET[2]` high for 16 clocks, then low. FN1 sel5 → no change.
- With `CPU_CTL_WATCHDOG_EN`, `WDT_LIMIT` = 4: four `VBLK` edges, no kick → `WDT_RST` is a single-clock pulse at the 4th edge. Kick after the 3rd edge → no pulse through the 6th edge.
- `RESET` asserted while `rcnt` = 7 and `pend` = 1 → next clock `CPU_RESET` = `RST_INIT`, `IRQ` = 0.
